sys_mode_ctrl: RTL and testbench

//  Parametrised successor to the system control block. Sequences camera configuration after power-up.

---
 rtl/sys_mode_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sys_mode_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_mode_ctrl.sv
// System mode controller: power-up camera config sequencing, debounced mode/filter controls,
// and frame-aligned application of changes behind a pipeline flush. Option macro: SYS_CFG_RETRY_EN.
module sys_mode_ctrl #(
    parameter int N_MODES       = 4,
    parameter int N_FILT        = 2,
    parameter int DB_COUNT      = 2500000,
    parameter int CFG_DELAY     = 1250000,
    parameter int FLUSH_TIMEOUT = 1024,
    parameter int CFG_TIMEOUT   = 12500000,
    localparam int MW           = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic              i_sysclk,
    input  logic              i_rstn,
    input  logic              i_sof,
    input  logic              i_btn_mode,
    input  logic [N_FILT-1:0] i_sw_filt,
    input  logic              i_cfg_done,
    input  logic              i_flush_done,
    output logic              o_cfg_start,
    output logic [MW-1:0]     o_mode,
    output logic [N_FILT-1:0] o_filt_en,
    output logic              o_pipe_flush,
    output logic [3:0]        o_status_leds
);

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_ARM   = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam int NCH = N_FILT + 1;
    localparam int DBW = $clog2(DB_COUNT + 1);
    localparam logic [DBW-1:0] DB_TERM   = DBW'(DB_COUNT - 1);
    localparam logic [MW-1:0]  MODE_LAST = MW'(N_MODES - 1);

`ifdef SYS_CFG_RETRY_EN
    localparam int T_MAX = (CFG_TIMEOUT > CFG_DELAY && CFG_TIMEOUT > FLUSH_TIMEOUT) ? CFG_TIMEOUT :
                           ((CFG_DELAY > FLUSH_TIMEOUT) ? CFG_DELAY : FLUSH_TIMEOUT);
`else
    localparam int T_MAX = (CFG_DELAY > FLUSH_TIMEOUT) ? CFG_DELAY : FLUSH_TIMEOUT;
`endif
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] T_PWRUP = TW'(CFG_DELAY - 1);
    localparam logic [TW-1:0] T_FLUSH = TW'(FLUSH_TIMEOUT - 1);
`ifdef SYS_CFG_RETRY_EN
    localparam logic [TW-1:0] T_CFG   = TW'(CFG_TIMEOUT - 1);
`endif

    function automatic logic [MW-1:0] next_mode(input logic [MW-1:0] m);
        return (m == MODE_LAST) ? '0 : m + 1'b1;
    endfunction

    logic [NCH-1:0]    raw, sync_p0, sync_p1, db;
    logic [DBW-1:0]    db_cnt [NCH];
    logic              db_btn, btn_q;
    logic [N_FILT-1:0] db_sw;
    logic [2:0]        state;
    logic [TW-1:0]     timer;
    logic [MW-1:0]     pend_mode, snap_mode;
    logic [N_FILT-1:0] pend_filt, snap_filt;
    logic              flush_tmo, active, change;

    assign raw    = {i_sw_filt, i_btn_mode};
    assign db_btn = db[0];
    assign db_sw  = db[NCH-1:1];

    // Synchroniser stages, then per-channel debounce: a level is accepted after DB_COUNT differing samples
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db      <= '0;
            for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < NCH; i++) begin
                if (sync_p1[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TERM) begin
                    db[i]     <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign active = (state == S_RUN) || (state == S_ARM) || (state == S_FLUSH);
    assign change = (pend_mode != o_mode) || (pend_filt != o_filt_en);

    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            pend_mode <= '0;
            pend_filt <= '0;
            btn_q     <= 1'b0;
        end else begin
            pend_filt <= db_sw;
            btn_q     <= db_btn;
            if (active && db_btn && !btn_q) pend_mode <= next_mode(pend_mode);
        end
    end

    // Shared timer: power-up delay, flush timeout and (optionally) config retry interval
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_PWRUP;
            timer        <= '0;
            o_cfg_start  <= 1'b0;
            o_pipe_flush <= 1'b0;
            o_mode       <= '0;
            o_filt_en    <= '0;
            snap_mode    <= '0;
            snap_filt    <= '0;
            flush_tmo    <= 1'b0;
        end else begin
            o_cfg_start <= 1'b0;
            timer       <= timer + 1'b1;
            case (state)
                S_PWRUP: begin
                    if (timer == T_PWRUP) begin
                        state       <= S_CFG;
                        o_cfg_start <= 1'b1;
                        timer       <= '0;
                    end
                end
                S_CFG: begin
                    if (i_cfg_done) begin
                        state     <= S_RUN;
                        o_filt_en <= pend_filt;
                    end
`ifdef SYS_CFG_RETRY_EN
                    else if (timer == T_CFG) begin
                        o_cfg_start <= 1'b1;
                        timer       <= '0;
                    end
`endif
                end
                S_RUN: begin
                    if (change) state <= S_ARM;
                end
                S_ARM: begin
                    if (!change) begin
                        state <= S_RUN;
                    end else if (i_sof) begin
                        state        <= S_FLUSH;
                        snap_mode    <= pend_mode;
                        snap_filt    <= pend_filt;
                        o_pipe_flush <= 1'b1;
                        timer        <= '0;
                    end
                end
                S_FLUSH: begin
                    // A done that coincides with the terminal count wins and raises no flag
                    if (i_flush_done || timer == T_FLUSH) begin
                        state        <= S_RUN;
                        o_pipe_flush <= 1'b0;
                        o_mode       <= snap_mode;
                        o_filt_en    <= snap_filt;
                        if (!i_flush_done) flush_tmo <= 1'b1;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

    assign o_status_leds = {flush_tmo, active && change, o_pipe_flush, active};

endmodule

// File: tb/tb_sys_mode_ctrl.sv
// Testbench for sys_mode_ctrl: vector table of mode/filter changes with a scoreboard
// checked at each flush exit, plus hand-written power-up, bounce, edit-in-flush and reset sequences.
module tb_sys_mode_ctrl;

    localparam int N_MODES = 3, N_FILT = 2, DB_COUNT = 4, CFG_DELAY = 10,
                   FLUSH_TIMEOUT = 32, CFG_TIMEOUT = 50;

    logic       clk = 1'b0, rst_n = 1'b0, sof = 1'b0, btn = 1'b0, cfg_done = 1'b0, flush_done = 1'b0;
    logic [1:0] sw = 2'b00;
    logic       cfg_start, pipe_flush;
    logic [1:0] mode, filt;
    logic [3:0] leds;

    always #5 clk = ~clk;

    sys_mode_ctrl #(
        .N_MODES(N_MODES), .N_FILT(N_FILT), .DB_COUNT(DB_COUNT), .CFG_DELAY(CFG_DELAY),
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT), .CFG_TIMEOUT(CFG_TIMEOUT)
    ) dut (
        .i_sysclk(clk), .i_rstn(rst_n), .i_sof(sof), .i_btn_mode(btn), .i_sw_filt(sw),
        .i_cfg_done(cfg_done), .i_flush_done(flush_done), .o_cfg_start(cfg_start),
        .o_mode(mode), .o_filt_en(filt), .o_pipe_flush(pipe_flush), .o_status_leds(leds)
    );

    typedef struct {
        bit         press;
        logic [1:0] sw;
        int         sof_wait;
        int         done_dly;
        logic [1:0] mode;
        logic [1:0] filt;
        bit         tmo;
    } vec_t;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] filt;
        bit         tmo;
        int         len;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0, n_err = 0;
    logic [1:0] cur_mode = 2'd0, cur_filt = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn = 1'b1;
        cyc(DB_COUNT + 6);
        btn = 1'b0;
        cyc(DB_COUNT + 6);
    endtask

    task automatic wait_led2(input bit v, input string name);
        int k = 0;
        while (leds[2] !== v && k < 50) begin
            cyc(1);
            k++;
        end
        check(name, leds[2], v);
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        cyc(1);
        sof = 1'b0;
    endtask

    task automatic count_flush(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1);
            if (pipe_flush === 1'b1) hi++;
        end
    endtask

    task automatic do_flush(input int sof_wait, input int dly, input int mid_sw, input exp_t e);
        exp_t got;
        int   len, k;
        cyc(sof_wait);
        check("no_flush_before_sof", pipe_flush, 1'b0);
        check("filt_before_sof", filt, cur_filt);
        sof = 1'b1;
        sb.push_back(e);
        cyc(1);
        sof = 1'b0;
        k = 0;
        while (pipe_flush !== 1'b1 && k < 5) begin
            cyc(1);
            k++;
        end
        check("flush_rise", pipe_flush, 1'b1);
        check("mode_held", mode, cur_mode);
        check("filt_held", filt, cur_filt);
        len = 0;
        while (pipe_flush === 1'b1 && len < 60) begin
            len++;
            if (len == dly) flush_done = 1'b1;
            if (len == 2 && mid_sw >= 0) sw = mid_sw[1:0];
            cyc(1);
            flush_done = 1'b0;
        end
        got = sb.pop_front();
        check("mode_applied", mode, got.mode);
        check("filt_applied", filt, got.filt);
        check("tmo_led", leds[3], got.tmo);
        check("flush_len", len, got.len);
        cur_mode = got.mode;
        cur_filt = got.filt;
    endtask

    vec_t vt[7];

    initial begin
        exp_t e;
        int   pulses, first, hi, exp_pulses;

        vt[0] = '{1'b1, 2'b00,   3,  3, 2'd1, 2'b00, 1'b0};
        vt[1] = '{1'b1, 2'b00,   3,  4, 2'd2, 2'b00, 1'b0};
        vt[2] = '{1'b1, 2'b00,   3,  5, 2'd0, 2'b00, 1'b0};
        vt[3] = '{1'b0, 2'b01, 200,  5, 2'd0, 2'b01, 1'b0};
        vt[4] = '{1'b1, 2'b11,   3,  2, 2'd1, 2'b11, 1'b0};
        vt[5] = '{1'b1, 2'b11,   3, -1, 2'd2, 2'b11, 1'b1};
        vt[6] = '{1'b1, 2'b10,   3,  4, 2'd0, 2'b10, 1'b1};

        // Reset state
        cyc(3);
        check("rst_cfg_start", cfg_start, 1'b0);
        check("rst_mode", mode, 2'd0);
        check("rst_filt", filt, 2'b00);
        check("rst_flush", pipe_flush, 1'b0);
        check("rst_leds", leds, 4'b0000);

        // Power-up: one config pulse at CFG_DELAY, running after cfg_done
        rst_n  = 1'b1;
        pulses = 0;
        first  = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            if (cfg_start === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (c == 20) cfg_done = 1'b1;
        end
        check("cfg_pulses", pulses, 1);
        check("cfg_pulse_cycle", first, CFG_DELAY);
        check("running_led", leds[0], 1'b1);

        for (int i = 0; i < 7; i++) begin
            sw = vt[i].sw;
            if (vt[i].press) press();
            wait_led2(1'b1, "pending_set");
            e.mode = vt[i].mode;
            e.filt = vt[i].filt;
            e.tmo  = vt[i].tmo;
            e.len  = (vt[i].done_dly < 0) ? FLUSH_TIMEOUT : vt[i].done_dly;
            do_flush(vt[i].sof_wait, vt[i].done_dly, -1, e);
            cyc(10);
            check("no_pending_after", leds[2], 1'b0);
            check("no_reflush", pipe_flush, 1'b0);
        end

        // Bouncing button: exactly one increment
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            cyc(2);
        end
        btn = 1'b1;
        cyc(DB_COUNT + 6);
        wait_led2(1'b1, "bounce_pending");
        e = '{2'd1, 2'b10, 1'b1, 4};
        do_flush(3, 4, -1, e);
        btn = 1'b0;
        cyc(DB_COUNT + 6);
        check("bounce_single", leds[2], 1'b0);

        // Switch edit during flush: snapshot applied, then re-arm
        press();
        wait_led2(1'b1, "edit_pending");
        e = '{2'd2, 2'b10, 1'b1, 20};
        do_flush(3, 20, 1, e);
        wait_led2(1'b1, "rearm_pending");
        e = '{2'd2, 2'b01, 1'b1, 3};
        do_flush(3, 3, -1, e);
        cyc(5);

        // sof and flush_done outside their states are ignored
        pulse_sof();
        flush_done = 1'b1;
        cyc(1);
        flush_done = 1'b0;
        count_flush(10, hi);
        check("sof_ignored", hi, 0);
        check("idle_mode", mode, cur_mode);
        check("idle_filt", filt, cur_filt);

        // Change withdrawn before sof: no flush
        sw = 2'b11;
        wait_led2(1'b1, "withdraw_pending");
        sw = 2'b01;
        wait_led2(1'b0, "withdraw_clear");
        cyc(2);
        pulse_sof();
        count_flush(10, hi);
        check("withdraw_noflush", hi, 0);
        check("withdraw_filt", filt, cur_filt);

        // Reset mid-flush, then config retry behaviour with cfg_done held low
        press();
        wait_led2(1'b1, "rstflush_pending");
        cyc(3);
        pulse_sof();
        cyc(3);
        check("rstflush_active", pipe_flush, 1'b1);
        #2 rst_n = 1'b0;
        cfg_done = 1'b0;
        #1;
        check("rst_async_flush", pipe_flush, 1'b0);
        check("rst_async_mode", mode, 2'd0);
        check("rst_async_leds", leds, 4'b0000);
        cyc(2);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 185; c++) begin
            cyc(1);
            if (cfg_start === 1'b1) pulses++;
        end
`ifdef SYS_CFG_RETRY_EN
        exp_pulses = 4;
`else
        exp_pulses = 1;
`endif
        check("retry_pulses", pulses, exp_pulses);
        check("not_running", leds[0], 1'b0);
        cfg_done = 1'b1;
        cyc(3);
        check("running_again", leds[0], 1'b1);
        check("tmo_cleared", leds[3], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
